// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one multiplier among NREQ clients.
// Sequences clear/start/wait on the multiplier with a watchdog abort.
module mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [7:0]              err_count,
  output logic                    mul_reset,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_multiplicand,
  output logic [WIDTH-1:0]        mul_multiplier,
  input  logic [2*WIDTH-1:0]      mul_product,
  input  logic                    mul_done
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, CLR, LOAD, WAIT, RESP
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     win_q;
  logic [TW-1:0]     wd_q;
  logic [7:0]        err_q;
  logic [WIDTH-1:0]  opa_q, opb_q;
  logic [2*WIDTH-1:0] prod_q;
  logic              rerr_q;

  logic [PW-1:0]     pick;
  logic [NREQ-1:0]   win_oh;
  logic              wd_hit;
  int                j;

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    pick = '0;
    j    = 0;
    for (int i = NREQ-1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[PW'(j)]) pick = PW'(j);
    end
  end

  assign wd_hit = (wd_q == TW'(TIMEOUT-1));
  assign win_oh = NREQ'(1) << win_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = CLR;
      CLR:     state_d = LOAD;
      LOAD:    state_d = WAIT;
      WAIT:    if (mul_done || wd_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      win_q  <= '0;
      wd_q   <= '0;
      err_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      prod_q <= '0;
      rerr_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (|req) begin
            win_q <= pick;
            ptr_q <= (pick == PW'(NREQ-1)) ? '0 : pick + 1'b1;
            opa_q <= WIDTH'(a_in >> (int'(pick)*WIDTH));
            opb_q <= WIDTH'(b_in >> (int'(pick)*WIDTH));
          end
        end
        WAIT: begin
          wd_q <= wd_q + 1'b1;
          if (mul_done) begin
            prod_q <= mul_product;
            rerr_q <= 1'b0;
          end else if (wd_hit) begin
            prod_q <= '0;
            rerr_q <= 1'b1;
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
          end
        end
        default: wd_q <= '0;
      endcase
    end
  end

  assign gnt              = (state_q == CLR)  ? win_oh : '0;
  assign rsp_valid        = (state_q == RESP) ? win_oh : '0;
  assign mul_reset        = (state_q == CLR);
  assign mul_start        = (state_q == LOAD);
  assign busy             = (state_q != IDLE);
  assign rsp_product      = prod_q;
  assign rsp_err          = rerr_q;
  assign err_count        = err_q;
  assign mul_multiplicand = opa_q;
  assign mul_multiplier   = opb_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: table vectors, corner sequences and random traffic
// against a behavioural multiplier and round-robin reference.
module tb_mult_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] a_in, b_in;
  logic [3:0]  gnt, rsp_valid;
  logic [7:0]  rsp_product;
  logic        rsp_err, busy;
  logic [7:0]  err_count;
  logic        mul_reset, mul_start;
  logic [3:0]  mul_multiplicand, mul_multiplier;
  logic [7:0]  mul_product;
  logic        mul_done;

  mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product),
    .rsp_err(rsp_err), .busy(busy), .err_count(err_count),
    .mul_reset(mul_reset), .mul_start(mul_start),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: done appears lat_cfg edges after start.
  logic       done_q;
  logic [7:0] mprod_q;
  int         rem;
  int         lat_cfg = 0;
  bit         hang_cfg = 0;
  bit         stale = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0; rem <= 0; mprod_q <= '0;
    end else if (mul_reset) begin
      done_q <= 1'b0; rem <= 0;
    end else if (mul_start) begin
      mprod_q <= mul_multiplicand * mul_multiplier;
      if (!hang_cfg) begin
        if (lat_cfg == 0) done_q <= 1'b1;
        else rem <= lat_cfg;
      end
    end else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 1) done_q <= 1'b1;
    end
  end

  assign mul_done    = done_q | stale;
  assign mul_product = stale ? 8'hAA : mprod_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  int mptr = 0;
  int merr = 0;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (((r >> ((p + i) % NREQ)) & 4'd1) != 4'd0) return (p + i) % NREQ;
    return -1;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] v, input int k);
    return 4'(v >> (k * 4));
  endfunction

  task automatic run_op(input string nm, input logic [3:0] rq,
                        input logic [15:0] a, input logic [15:0] b,
                        input int lat, input bit hang, input bit stl,
                        input int ew, input logic [7:0] ep, input bit ee);
    int cyc;
    int want;
    logic [3:0] oh;
    oh = 4'd1 << ew;
    req = rq; a_in = a; b_in = b;
    lat_cfg = lat; hang_cfg = hang; stale = stl;
    @(negedge clk);
    chk({nm, " gnt"}, 32'(gnt), 32'(oh));
    chk({nm, " mul_reset"}, 32'(mul_reset), 1);
    chk({nm, " opA"}, 32'(mul_multiplicand), 32'(nib(a, ew)));
    chk({nm, " opB"}, 32'(mul_multiplier), 32'(nib(b, ew)));
    req = req & ~gnt;
    @(negedge clk);
    chk({nm, " start/gnt"}, {31'(gnt), mul_start}, 1);
    cyc = 2;
    while (rsp_valid == 4'd0 && cyc < 3 + TIMEOUT + 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) stale = 1'b0;
    end
    want = hang ? 3 + TIMEOUT : 4 + lat;
    chk({nm, " latency"}, 32'(cyc), 32'(want));
    chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(oh));
    chk({nm, " product"}, 32'(rsp_product), 32'(ep));
    chk({nm, " err"}, 32'(rsp_err), 32'(ee));
    @(negedge clk);
    chk({nm, " idle"}, {27'(rsp_valid), busy}, 0);
  endtask

  typedef struct {
    logic [3:0]  rq;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    int          ew;
    logic [7:0]  ep;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int any;
    int w;
    logic [3:0]  rq;
    logic [15:0] ra, rb;
    int          rl;
    bit          rh;
    logic [7:0]  ep;

    tbl[0] = '{4'b0011, {4'd0, 4'd0, 4'd15, 4'd7},
               {4'd0, 4'd0, 4'd15, 4'd9}, 0, 0, 8'd63};
    tbl[1] = '{4'b0010, {4'd0, 4'd0, 4'd15, 4'd7},
               {4'd0, 4'd0, 4'd15, 4'd9}, 1, 1, 8'd225};
    tbl[2] = '{4'b0001, {4'd0, 4'd0, 4'd0, 4'd4},
               {4'd0, 4'd0, 4'd0, 4'd3}, 3, 0, 8'd12};
    tbl[3] = '{4'b1000, {4'd2, 4'd0, 4'd0, 4'd0},
               {4'd8, 4'd0, 4'd0, 4'd0}, 2, 3, 8'd16};
    tbl[4] = '{4'b1111, {4'd15, 4'd13, 4'd9, 4'd5},
               {4'd1, 4'd14, 4'd11, 4'd6}, 0, 0, 8'd30};
    tbl[5] = '{4'b1111, {4'd15, 4'd13, 4'd9, 4'd5},
               {4'd1, 4'd14, 4'd11, 4'd6}, 4, 1, 8'd99};
    tbl[6] = '{4'b1111, {4'd15, 4'd13, 4'd9, 4'd5},
               {4'd1, 4'd14, 4'd11, 4'd6}, 1, 2, 8'd182};
    tbl[7] = '{4'b1111, {4'd15, 4'd13, 4'd9, 4'd5},
               {4'd1, 4'd14, 4'd11, 4'd6}, 5, 3, 8'd15};
    tbl[8] = '{4'b1111, {4'd15, 4'd13, 4'd9, 4'd0},
               {4'd1, 4'd14, 4'd11, 4'd12}, 2, 0, 8'd0};

    reset = 1'b1; req = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset out0", {gnt, rsp_valid, rsp_product, rsp_err, busy,
                       mul_reset, mul_start}, 0);
    chk("reset out1", {err_count, mul_multiplicand, mul_multiplier}, 0);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].rq, tbl[i].a, tbl[i].b,
             tbl[i].lat, 1'b0, 1'b0, tbl[i].ew, tbl[i].ep, 1'b0);
      mptr = (tbl[i].ew + 1) % NREQ;
    end

    w = rr_pick(4'b0100, mptr);
    run_op("timeout", 4'b0100, 16'h0300, 16'h0300, 0, 1'b1, 1'b0,
           w, 8'd0, 1'b1);
    mptr = (w + 1) % NREQ;
    merr++;
    chk("timeout err_count", 32'(err_count), 32'(merr));

    w = rr_pick(4'b0001, mptr);
    run_op("after_to", 4'b0001, 16'h0006, 16'h0007, 1, 1'b0, 1'b0,
           w, 8'd42, 1'b0);
    mptr = (w + 1) % NREQ;

    w = rr_pick(4'b0010, mptr);
    run_op("stale", 4'b0010, 16'h0050, 16'h0050, 2, 1'b0, 1'b1,
           w, 8'd25, 1'b0);
    mptr = (w + 1) % NREQ;

    req = 4'b0100; a_in = 16'h0300; b_in = 16'h0300; hang_cfg = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstwait out0", {gnt, rsp_valid, rsp_product, rsp_err, busy,
                         mul_reset, mul_start}, 0);
    chk("rstwait out1", {err_count, mul_multiplicand, mul_multiplier}, 0);
    req = '0; hang_cfg = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mptr = 0; merr = 0;
    any = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid != 4'd0) any++;
    end
    chk("rstwait no_rsp", 32'(any), 0);
    run_op("post_reset", 4'b0001, 16'h0002, 16'h0005, 1, 1'b0, 1'b0,
           0, 8'd10, 1'b0);
    mptr = 1;

    for (int i = 0; i < 40; i++) begin
      rq = 4'($urandom_range(1, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rl = $urandom_range(0, 6);
      rh = ($urandom_range(0, 9) == 0);
      w  = rr_pick(rq, mptr);
      ep = rh ? 8'd0 : 8'(nib(ra, w) * nib(rb, w));
      run_op($sformatf("rnd%0d", i), rq, ra, rb, rl, rh, 1'b0,
             w, ep, rh);
      mptr = (w + 1) % NREQ;
      if (rh) merr++;
    end
    chk("final err_count", 32'(err_count), 32'(merr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one `RTL_multiply` instance among `NREQ` requesters. It accepts one operand pair at a time and drives the multiplier's reset/start/operand inputs through its clear–start–wait protocol. It returns the registered product to the granted requester and aborts hung operations with a watchdog. It sits between client logic and the single multiplier datapath.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 4: operand width; product is `2*WIDTH`.
- `TIMEOUT`, 64: maximum cycles in WAIT before abort (≥ 2).

Ports (`a_in`/`b_in` are flattened; requester i uses bits `[i*WIDTH +: WIDTH]`):
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req`  in  NREQ  per-requester request level.
- `a_in`  in  NREQ*WIDTH  multiplicands, flattened.
- `b_in`  in  NREQ*WIDTH  multipliers, flattened.
- `gnt`  out  NREQ  one-hot, 1-cycle pulse: operands captured.
- `rsp_valid`  out  NREQ  one-hot, 1-cycle pulse: result available.
- `rsp_product`  out  2*WIDTH  result, valid with `rsp_valid`.
- `rsp_err`  out  1  qualifies `rsp_valid`: operation timed out.
- `busy`  out  1  high whenever state ≠ IDLE.
- `err_count`  out  8  saturating count of timeouts.
- `mul_reset`  out  1  synchronous clear pulse to multiplier.
- `mul_start`  out  1  start pulse to multiplier.
- `mul_multiplicand`  out  WIDTH  operand A to multiplier.
- `mul_multiplier`  out  WIDTH  operand B to multiplier.
- `mul_product`  in  2*WIDTH  multiplier result.
- `mul_done`  in  1  multiplier done; level, held until `mul_reset`.

## Operation
- FSM states: IDLE, CLR, LOAD, WAIT, RESP.
- **IDLE**
  - If any `req` is set, select the winner round-robin, starting from `ptr`.
  - Capture the winner's operands into the `mul_*` operand registers.
  - Register the winner index, then go to CLR.
  - With no request, stay in IDLE.
- **Round-robin pointer:** `ptr` resets to 0. After each grant, `ptr` = (winner+1) mod `NREQ`.
- **CLR**
  - `gnt[winner]`=1 and `mul_reset`=1 for this one cycle; go to LOAD.
  - Clearing the multiplier before every operation removes a stale `done`.
- **LOAD:** `mul_start`=1 for one cycle; go to WAIT. `mul_done` is ignored in CLR and LOAD.
- **WAIT**
  - Watchdog counter starts at 0 on entry and increments each cycle.
  - If `mul_done`=1: register `mul_product` into `rsp_product`, `rsp_err`=0, go to RESP.
  - Else, if the counter reaches `TIMEOUT`-1: `rsp_product`=0, `rsp_err`=1, increment `err_count` (saturating at 255), go to RESP.
  - If `mul_done` rises on the timeout cycle, `done` wins.
- **RESP:** `rsp_valid[winner]`=1 for one cycle; go to IDLE.
- **Operand buses:** `mul_multiplicand`/`mul_multiplier` hold their value from the capture edge until the next capture.
- **Requester rules**
  - Hold `req` and the operands stable until `gnt` is seen.
  - Drop `req` by the cycle after `gnt`; a `req` still high at the next IDLE is a new request.
  - A request dropped before grant is simply never served.
- **Arithmetic:** the product is passed through unmodified, `2*WIDTH` bits. No truncation is possible.

## Timing
- Reset values:
  - All outputs are 0; `mul_multiplicand`/`mul_multiplier` are 0.
  - State is IDLE; `ptr`=0; watchdog=0; `err_count`=0.
- **Reset asserted mid-operation:** returns to IDLE immediately with all pulses cleared. No `rsp_valid` is issued for the aborted operation.
- **Cycle sequence:** request sampled in IDLE at edge E0.
  - E0→E1: CLR, so `gnt` and `mul_reset` are high in cycle 1.
  - Cycle 2: LOAD, `mul_start` high.
  - Cycle 3+: WAIT.
- **Response latency:** if `mul_done` is first sampled high at WAIT cycle k (k≥0), `rsp_valid` is high at cycle 4+k.
- **Throughput:** IDLE occupies one cycle between operations, so the next `gnt` comes no earlier than 2 cycles after `rsp_valid`.
- **Timeout response:** `rsp_valid` with `rsp_err` at cycle 3+`TIMEOUT`.

## Test plan
- **Single request:** `req`=0001, a=4, b=3 → `gnt`=0001 one cycle; `mul_reset`, then `mul_start`; `rsp_valid`=0001, `rsp_product`=12, `rsp_err`=0.
- **Concurrent requests:** `req`=0011, req0 a=7 b=9 and req1 a=15 b=15 held until grant → grant order 0 then 1; products 63 then 225; `ptr`=2 afterwards.
- **Fairness:** all four `req` held continuously with new operands after each `gnt` → grants cycle 0,1,2,3,0; no requester is granted twice within 4 grants.
- **Timeout:** model holds `mul_done`=0 → `rsp_valid` with `rsp_err`=1 and `rsp_product`=0 exactly 3+64 cycles after IDLE sampling; `err_count`=1. The next request completes normally.
- **Stale done:** `mul_done` forced high during CLR/LOAD → ignored; the response uses the `done` after `mul_reset`.
- **Reset in WAIT:** assert `reset` during WAIT → all outputs 0, no `rsp_valid`. A subsequent 2×5 request returns 10.
